result_packer: RTL and testbench

RESULT_PACKER -- requirements
Module: result_packer

---
 rtl/result_packer.sv | 157 +++++++++++++++
 tb/tb_result_packer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/result_packer.sv
// result_packer: packs DATA_W-bit samples into PACK_N-lane words and
// queues them in a FIFO_DEPTH-entry output FIFO with a sticky overflow flag.
module result_packer #(
  parameter int unsigned DATA_W     = 4,
  parameter int unsigned PACK_N     = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [DATA_W-1:0]                  in_data,
  input  logic                               in_valid,
  input  logic                               flush,
  input  logic                               ovf_clr,
  output logic [DATA_W*PACK_N-1:0]           out_data,
  output logic [PACK_N-1:0]                  out_keep,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    level,
  output logic                               overflow
);

  localparam int unsigned WORD_W = DATA_W * PACK_N;
  localparam int unsigned CNT_W  = $clog2(PACK_N);
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W  = $clog2(FIFO_DEPTH + 1);

  // Packing state
  logic [CNT_W-1:0]              lane_cnt;
  logic [PACK_N-1:0][DATA_W-1:0] lanes;

  // FIFO storage and pointers
  logic [WORD_W-1:0] mem_data [FIFO_DEPTH];
  logic [PACK_N-1:0] mem_keep [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  // Combinational next-state terms
  logic [WORD_W-1:0] word_c;
  logic [PACK_N-1:0] keep_c;
  logic              complete_c;
  logic              push_c;
  logic              pop_c;
  logic              full_c;
  logic              write_c;
  logic              drop_c;
  logic [PTR_W-1:0]  rd_next_c;
  logic [LVL_W-1:0]  level_next_c;
  logic [WORD_W-1:0] head_data_c;
  logic [PACK_N-1:0] head_keep_c;

  // Assemble the candidate word: stored lanes plus this cycle's sample, zeros above
  always_comb begin
    word_c = '0;
    keep_c = '0;
    for (int unsigned i = 0; i < PACK_N; i++) begin
      if (CNT_W'(i) < lane_cnt) begin
        word_c[i*DATA_W +: DATA_W] = lanes[i];
        keep_c[i]                  = 1'b1;
      end else if (in_valid && (CNT_W'(i) == lane_cnt)) begin
        word_c[i*DATA_W +: DATA_W] = in_data;
        keep_c[i]                  = 1'b1;
      end
    end
  end

  // Push/pop decisions; a pop frees the slot a same-cycle push needs when full
  always_comb begin
    complete_c = in_valid && (lane_cnt == CNT_W'(PACK_N - 1));
    push_c     = complete_c || (flush && ((lane_cnt != '0) || in_valid));
    pop_c      = out_valid && out_ready;
    full_c     = (level == LVL_W'(FIFO_DEPTH));
    write_c    = push_c && (!full_c || pop_c);
    drop_c     = push_c && full_c && !pop_c;
  end

  // Next read pointer, occupancy and head word (bypass when the head is being written)
  always_comb begin
    rd_next_c    = pop_c ? rd_ptr + PTR_W'(1) : rd_ptr;
    level_next_c = level;
    case ({write_c, pop_c})
      2'b10:   level_next_c = level + LVL_W'(1);
      2'b01:   level_next_c = level - LVL_W'(1);
      default: level_next_c = level;
    endcase
    head_data_c = '0;
    head_keep_c = '0;
    if (level_next_c != '0) begin
      if (write_c && (rd_next_c == wr_ptr)) begin
        head_data_c = word_c;
        head_keep_c = keep_c;
      end else begin
        head_data_c = mem_data[rd_next_c];
        head_keep_c = mem_keep[rd_next_c];
      end
    end
  end

  // Lane counter and lane storage; any push (or drop) restarts at lane 0
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lane_cnt <= '0;
      lanes    <= '0;
    end else if (push_c) begin
      lane_cnt <= '0;
      lanes    <= '0;
    end else if (in_valid) begin
      lanes[lane_cnt] <= in_data;
      lane_cnt        <= lane_cnt + CNT_W'(1);
    end
  end

  // FIFO array write
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_data[i] <= '0;
        mem_keep[i] <= '0;
      end
    end else if (write_c) begin
      mem_data[wr_ptr] <= word_c;
      mem_keep[wr_ptr] <= keep_c;
    end
  end

  // FIFO pointers, occupancy and registered head outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_keep  <= '0;
    end else begin
      if (write_c) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      rd_ptr    <= rd_next_c;
      level     <= level_next_c;
      out_valid <= (level_next_c != '0);
      out_data  <= head_data_c;
      out_keep  <= head_keep_c;
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear wins
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow <= 1'b0;
    end else if (drop_c) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_result_packer.sv
// Scoreboard bench for result_packer (DATA_W=4, PACK_N=4, FIFO_DEPTH=4).
module tb_result_packer;

  localparam int DW    = 4;
  localparam int PN    = 4;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  in_data;
  logic        in_valid;
  logic        flush;
  logic        ovf_clr;
  logic [15:0] out_data;
  logic [3:0]  out_keep;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  level;
  logic        overflow;

  result_packer #(.DATA_W(DW), .PACK_N(PN), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .flush(flush), .ovf_clr(ovf_clr), .out_data(out_data), .out_keep(out_keep),
    .out_valid(out_valid), .out_ready(out_ready), .level(level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: pending samples, expected words, occupancy, sticky flag
  logic [3:0]  part[$];
  logic [19:0] exp_q[$];
  int          mdl_cnt = 0;
  bit          exp_ovf = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every accepted handshake must match the oldest expected word
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL pop_unexpected: got %0h expected none", out_data);
      end else begin
        logic [19:0] e;
        e = exp_q.pop_front();
        chk("out_data", int'(out_data), int'(e[15:0]));
        chk("out_keep", int'(out_keep), int'(e[19:16]));
      end
    end
  end

  // One clock of stimulus; the model decides what the DUT must do with it
  task automatic cycle(input bit v, input logic [3:0] d, input bit fl,
                       input bit clr, input bit rdy);
    bit          pop;
    bit          drop;
    logic [15:0] w;
    logic [3:0]  k;
    in_valid  = v;
    in_data   = d;
    flush     = fl;
    ovf_clr   = clr;
    out_ready = rdy;
    pop  = (mdl_cnt > 0) && rdy;
    drop = 1'b0;
    if (v) part.push_back(d);
    if (part.size() == PN || (fl && part.size() > 0)) begin
      w = '0;
      foreach (part[i]) w = w | (16'(part[i]) << (DW * i));
      k = 4'((1 << part.size()) - 1);
      part.delete();
      if (mdl_cnt < DEPTH || pop) begin
        exp_q.push_back({k, w});
        mdl_cnt++;
      end else begin
        drop = 1'b1;
      end
    end
    if (pop) mdl_cnt--;
    if (drop) exp_ovf = 1'b1;
    else if (clr) exp_ovf = 1'b0;
    @(posedge clk);
    #1;
    chk("level", int'(level), mdl_cnt);
    chk("out_valid", int'(out_valid), int'(mdl_cnt != 0));
    chk("overflow", int'(overflow), int'(exp_ovf));
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, 4'h0, 1'b0, 1'b0, rdy);
  endtask

  task automatic drain();
    int budget = 40;
    while (mdl_cnt > 0 && budget > 0) begin
      cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
      budget--;
    end
    chk("drain_level", int'(level), 0);
    chk("drain_sb_empty", exp_q.size(), 0);
  endtask

  // Asynchronous reset pulse with samples presented during reset
  task automatic pulse_reset();
    rst = 1'b0;
    #1;
    chk("rst_level", int'(level), 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_keep", int'(out_keep), 0);
    chk("rst_data", int'(out_data), 0);
    chk("rst_ovf", int'(overflow), 0);
    part.delete();
    exp_q.delete();
    mdl_cnt = 0;
    exp_ovf = 1'b0;
    in_valid = 1'b1;
    in_data  = 4'h5;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; in_data = '0; in_valid = 1'b0; flush = 1'b0;
    ovf_clr = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("init_level", int'(level), 0);
    chk("init_valid", int'(out_valid), 0);
    chk("init_ovf", int'(overflow), 0);
    chk("init_data", int'(out_data), 0);
    chk("init_keep", int'(out_keep), 0);
    rst = 1'b1;

    // Full word 1,2,3,4 -> 4321
    for (int i = 1; i <= 4; i++) cycle(1'b1, 4'(i), 1'b0, 1'b0, 1'b1);
    idle(2, 1'b1);

    // Partial 5,6 flushed, then 7 must land in lane 0
    cycle(1'b1, 4'h5, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 4'h6, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 4'h0, 1'b1, 1'b0, 1'b1);
    for (int i = 7; i <= 10; i++) cycle(1'b1, 4'(i), 1'b0, 1'b0, 1'b1);
    idle(2, 1'b1);

    // Flush with nothing pending pushes nothing
    cycle(1'b0, 4'h0, 1'b1, 1'b0, 1'b1);
    idle(1, 1'b1);

    // Overflow: 5 words with no drain, then drain 4 and clear
    for (int i = 0; i < 20; i++) cycle(1'b1, 4'(i), 1'b0, 1'b0, 1'b0);
    drain();
    cycle(1'b0, 4'h0, 1'b0, 1'b1, 1'b1);

    // Full FIFO, completing sample together with a pop: no drop
    for (int i = 0; i < 16; i++) cycle(1'b1, 4'(15 - i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 4'(i + 3), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 4'hE, 1'b0, 1'b0, 1'b1);
    drain();

    // Drop and clear in the same cycle: set wins
    for (int i = 0; i < 16; i++) cycle(1'b1, 4'(i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 4'(i), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 4'h7, 1'b0, 1'b1, 1'b0);

    // Reset mid-word with FIFO holding data, then 9,A,B,C
    for (int i = 0; i < 2; i++) cycle(1'b1, 4'(i), 1'b0, 1'b0, 1'b0);
    pulse_reset();
    for (int i = 9; i <= 12; i++) cycle(1'b1, 4'(i), 1'b0, 1'b0, 1'b1);
    idle(2, 1'b1);

    // Completing sample with flush in the same cycle -> one word 3210
    for (int i = 0; i < 3; i++) cycle(1'b1, 4'(i), 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 4'h3, 1'b1, 1'b0, 1'b1);
    idle(2, 1'b1);

    // Flush with a lone sample at lane 0 -> one-lane word
    cycle(1'b1, 4'hA, 1'b1, 1'b0, 1'b1);
    idle(2, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(9, 0) < 7), 4'($urandom_range(15, 0)),
            ($urandom_range(9, 0) == 0), ($urandom_range(19, 0) == 0),
            ($urandom_range(1, 0) == 1));
    end
    cycle(1'b0, 4'h0, 1'b1, 1'b1, 1'b1);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
